diff_uart_rx: RTL and testbench



---
 rtl/diff_uart_rx_pkg.sv | 22 ++
 rtl/diff_rx_fifo.sv | 90 +++++++++
 rtl/diff_uart_rx.sv | 207 ++++++++++++++++++++
 tb/tb_diff_uart_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_uart_rx_pkg.sv
// Shared definitions for the differential 8N1 receiver: FSM state encoding,
// oversample tick constants and data width.
package diff_uart_rx_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TICK_W = 4;
  localparam int unsigned BIT_W  = 3;

  // Mid-point of the start bit and end of a full 16-tick bit period.
  localparam logic [TICK_W-1:0] TICK_MID = 4'd7;
  localparam logic [TICK_W-1:0] TICK_END = 4'd15;
  localparam logic [BIT_W-1:0]  BIT_LAST = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/diff_rx_fifo.sv
// First-word-fall-through receive buffer with registered status flags.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   write, wdata         push request and byte
//   read                 pop head (ignored when empty)
//   data_out             registered head entry
//   data_present         >=1 entry stored
//   half_full            count >= FIFO_DEPTH/2
//   full                 count == FIFO_DEPTH
//   overrun              one-clk pulse when a write is dropped
module diff_rx_fifo
  import diff_uart_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              write,
  input  logic [DATA_W-1:0] wdata,
  input  logic              read,
  output logic [DATA_W-1:0] data_out,
  output logic              data_present,
  output logic              half_full,
  output logic              full,
  output logic              overrun
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(FIFO_DEPTH / 2);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_n;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_n;
  logic [CNT_W-1:0]  count_q, count_n, count_after_pop;
  logic [DATA_W-1:0] head_n;
  logic              pop, push, drop, is_full;

  // Pop/push arbitration; a pop frees the slot a full-buffer write needs.
  always_comb begin
    is_full  = (count_q == CNT_FULL);
    pop      = read && (count_q != '0);
    push     = write && (!is_full || pop);
    drop     = write && is_full && !pop;
    rd_ptr_n = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_n = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_after_pop = pop ? count_q - CNT_W'(1) : count_q;
    count_n  = push ? count_after_pop + CNT_W'(1) : count_after_pop;
    // Head comes straight from wdata when the write lands in an empty buffer.
    if (count_n == '0) begin
      head_n = data_out;
    end else if (push && (count_after_pop == '0)) begin
      head_n = wdata;
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers, count and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      data_out     <= '0;
      data_present <= 1'b0;
      half_full    <= 1'b0;
      full         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_n;
      wr_ptr_q     <= wr_ptr_n;
      count_q      <= count_n;
      data_out     <= head_n;
      data_present <= (count_n != '0);
      half_full    <= (count_n >= CNT_HALF);
      full         <= (count_n == CNT_FULL);
      overrun      <= drop;
    end
  end

endmodule

// File: rtl/diff_uart_rx.sv
// Differential-pair 8N1 UART receiver with FWFT output buffer.
// Optional pair integrity check enabled by macro DIFF_UART_RX_PAIR_CHECK_EN;
// without it the line is taken from I alone and pair_fault is tied low.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   I, IB                 differential positive / negative legs
//   en_16_x_baud          one-clk pulse at 16x bit rate
//   read_buffer           pop head entry
//   data_out              head entry
//   buffer_data_present   buffer holds >=1 byte
//   buffer_half_full      count >= FIFO_DEPTH/2
//   buffer_full           count == FIFO_DEPTH
//   framing_error         one-clk pulse, stop bit sampled low
//   overrun               one-clk pulse, good byte dropped
//   pair_fault            level, legs equal for PAIR_FAULT_CYCLES cycles
module diff_uart_rx
  import diff_uart_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned PAIR_FAULT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              I,
  input  logic              IB,
  input  logic              en_16_x_baud,
  input  logic              read_buffer,
  output logic [DATA_W-1:0] data_out,
  output logic              buffer_data_present,
  output logic              buffer_half_full,
  output logic              buffer_full,
  output logic              framing_error,
  output logic              overrun,
  output logic              pair_fault
);

  logic [1:0] i_sync;
  logic       s_i;
  logic       rx;

  // Two-flop synchroniser on the positive leg; resets to idle-high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_sync <= 2'b11;
    end else begin
      i_sync <= {i_sync[0], I};
    end
  end

  assign s_i = i_sync[1];

`ifdef DIFF_UART_RX_PAIR_CHECK_EN
  localparam int unsigned PF_W = $clog2(PAIR_FAULT_CYCLES + 1);
  localparam logic [PF_W-1:0] PF_MAX = PF_W'(PAIR_FAULT_CYCLES);

  logic [1:0]      ib_sync;
  logic            s_ib;
  logic            legs_differ;
  logic            rx_hold;
  logic [PF_W-1:0] pair_cnt_q, pair_cnt_n;

  assign s_ib = ib_sync[1];

  // Line follows I only while the pair is valid; otherwise hold last level.
  always_comb begin
    legs_differ = s_i ^ s_ib;
    rx          = legs_differ ? s_i : rx_hold;
    if (legs_differ) begin
      pair_cnt_n = '0;
    end else if (pair_cnt_q == PF_MAX) begin
      pair_cnt_n = pair_cnt_q;
    end else begin
      pair_cnt_n = pair_cnt_q + PF_W'(1);
    end
  end

  // Negative-leg synchroniser, held line level and saturating fault counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ib_sync    <= 2'b00;
      rx_hold    <= 1'b1;
      pair_cnt_q <= '0;
      pair_fault <= 1'b0;
    end else begin
      ib_sync    <= {ib_sync[0], IB};
      rx_hold    <= rx;
      pair_cnt_q <= pair_cnt_n;
      pair_fault <= (pair_cnt_n == PF_MAX);
    end
  end
`else
  logic unused_ib;
  localparam int unsigned unused_pair_cycles = PAIR_FAULT_CYCLES;

  assign unused_ib  = IB;
  assign pair_fault = 1'b0;

  always_comb begin
    rx = s_i;
  end
`endif

  rx_state_e         state_q, state_n;
  logic [TICK_W-1:0] tick_q, tick_n;
  logic [BIT_W-1:0]  bit_q, bit_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              fifo_write;
  logic              ferr_n;

  // Frame decoder, advancing only on the 16x baud enable.
  always_comb begin
    state_n    = state_q;
    tick_n     = tick_q;
    bit_n      = bit_q;
    shift_n    = shift_q;
    fifo_write = 1'b0;
    ferr_n     = 1'b0;
    if (en_16_x_baud) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx) begin
            state_n = ST_START;
            tick_n  = '0;
          end
        end
        ST_START: begin
          if (tick_q == TICK_MID) begin
            tick_n  = '0;
            bit_n   = '0;
            // A start bit that is high again at its midpoint was a glitch.
            state_n = rx ? ST_IDLE : ST_DATA;
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_q == TICK_END) begin
            shift_n[bit_q] = rx;
            tick_n         = '0;
            if (bit_q == BIT_LAST) begin
              state_n = ST_STOP;
            end else begin
              bit_n = bit_q + BIT_W'(1);
            end
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end
        ST_STOP: begin
          if (tick_q == TICK_END) begin
            tick_n = '0;
            if (rx) begin
              fifo_write = 1'b1;
              state_n    = ST_IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = ST_BREAK;
            end
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end
        ST_BREAK: begin
          if (rx) begin
            state_n = ST_IDLE;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Decoder state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      tick_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      framing_error <= 1'b0;
    end else begin
      state_q       <= state_n;
      tick_q        <= tick_n;
      bit_q         <= bit_n;
      shift_q       <= shift_n;
      framing_error <= ferr_n;
    end
  end

  diff_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .write        (fifo_write),
    .wdata        (shift_q),
    .read         (read_buffer),
    .data_out     (data_out),
    .data_present (buffer_data_present),
    .half_full    (buffer_half_full),
    .full         (buffer_full),
    .overrun      (overrun)
  );

endmodule

// File: tb/tb_diff_uart_rx.sv
// Directed self-checking bench for diff_uart_rx (FIFO_DEPTH=4, 16 enables/bit,
// enable every 4th clock, 64 clocks per bit).
module tb_diff_uart_rx;

  logic       clk;
  logic       reset_n;
  logic       I;
  logic       IB;
  logic       en_16_x_baud;
  logic       read_buffer;
  logic [7:0] data_out;
  logic       buffer_data_present;
  logic       buffer_half_full;
  logic       buffer_full;
  logic       framing_error;
  logic       overrun;
  logic       pair_fault;

  int checks = 0;
  int passed = 0;
  int fe_cycles = 0;
  int ov_cycles = 0;

  diff_uart_rx #(
    .FIFO_DEPTH(4),
    .PAIR_FAULT_CYCLES(8)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .I                   (I),
    .IB                  (IB),
    .en_16_x_baud        (en_16_x_baud),
    .read_buffer         (read_buffer),
    .data_out            (data_out),
    .buffer_data_present (buffer_data_present),
    .buffer_half_full    (buffer_half_full),
    .buffer_full         (buffer_full),
    .framing_error       (framing_error),
    .overrun             (overrun),
    .pair_fault          (pair_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    en_16_x_baud = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      en_16_x_baud = 1'b1;
      @(negedge clk);
      en_16_x_baud = 1'b0;
    end
  end

  // Pulse-cycle counters for the one-clk flags.
  always @(negedge clk) begin
    if (framing_error === 1'b1) fe_cycles <= fe_cycles + 1;
    if (overrun === 1'b1)       ov_cycles <= ov_cycles + 1;
  end

  task automatic set_line(input logic v);
    I  = v;
    IB = ~v;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    set_line(1'b0);
    wait_clks(64);
    for (int i = 0; i < 8; i++) begin
      set_line(b[i]);
      wait_clks(64);
    end
    set_line(stop);
    wait_clks(64);
  endtask

  task automatic do_read();
    @(negedge clk);
    read_buffer = 1'b1;
    @(negedge clk);
    read_buffer = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    read_buffer = 1'b0;
    set_line(1'b1);
    wait_clks(5);
    checks++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", data_out); else passed++;
    checks++; if ({buffer_data_present, buffer_half_full, buffer_full} !== 3'b000) $display("FAIL reset_buf_flags: got %b want 000", {buffer_data_present, buffer_half_full, buffer_full}); else passed++;
    checks++; if ({framing_error, overrun, pair_fault} !== 3'b000) $display("FAIL reset_err_flags: got %b want 000", {framing_error, overrun, pair_fault}); else passed++;
    reset_n = 1'b1;
    wait_clks(20);
    checks++; if ({buffer_data_present, framing_error, pair_fault} !== 3'b000) $display("FAIL idle_after_reset: got %b want 000", {buffer_data_present, framing_error, pair_fault}); else passed++;
  endtask

  task automatic test_byte();
    int fe0, ov0;
    fe0 = fe_cycles; ov0 = ov_cycles;
    send_frame(8'hA5, 1'b1);
    checks++; if (data_out !== 8'hA5) $display("FAIL byte_data: got %h want a5", data_out); else passed++;
    checks++; if ({buffer_data_present, buffer_half_full, buffer_full} !== 3'b100) $display("FAIL byte_flags: got %b want 100", {buffer_data_present, buffer_half_full, buffer_full}); else passed++;
    checks++; if ((fe_cycles - fe0) + (ov_cycles - ov0) !== 0) $display("FAIL byte_no_err: got %0d want 0", (fe_cycles - fe0) + (ov_cycles - ov0)); else passed++;
    do_read();
    checks++; if (buffer_data_present !== 1'b0) $display("FAIL byte_popped: got %b want 0", buffer_data_present); else passed++;
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cycles;
    set_line(1'b0);
    wait_clks(12);
    set_line(1'b1);
    wait_clks(700);
    checks++; if (buffer_data_present !== 1'b0) $display("FAIL glitch_empty: got %b want 0", buffer_data_present); else passed++;
    checks++; if (fe_cycles - fe0 !== 0) $display("FAIL glitch_no_ferr: got %0d want 0", fe_cycles - fe0); else passed++;
  endtask

  task automatic test_framing();
    int fe0;
    fe0 = fe_cycles;
    send_frame(8'h3C, 1'b0);
    wait_clks(300);
    checks++; if (fe_cycles - fe0 !== 1) $display("FAIL ferr_pulse: got %0d cycles want 1", fe_cycles - fe0); else passed++;
    checks++; if (buffer_data_present !== 1'b0) $display("FAIL ferr_no_write: got %b want 0", buffer_data_present); else passed++;
    set_line(1'b1);
    wait_clks(100);
    send_frame(8'h11, 1'b1);
    checks++; if (data_out !== 8'h11 || buffer_data_present !== 1'b1) $display("FAIL after_break: got %h/%b want 11/1", data_out, buffer_data_present); else passed++;
    checks++; if (fe_cycles - fe0 !== 1) $display("FAIL after_break_ferr: got %0d want 1", fe_cycles - fe0); else passed++;
    do_read();
  endtask

  task automatic test_overrun();
    int ov0;
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
    checks++; if ({buffer_data_present, buffer_half_full, buffer_full} !== 3'b111) $display("FAIL full_flags: got %b want 111", {buffer_data_present, buffer_half_full, buffer_full}); else passed++;
    ov0 = ov_cycles;
    send_frame(8'h05, 1'b1);
    checks++; if (ov_cycles - ov0 !== 1) $display("FAIL overrun_pulse: got %0d want 1", ov_cycles - ov0); else passed++;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (data_out !== 8'(k)) $display("FAIL ovr_read%0d: got %h want %h", k, data_out, 8'(k)); else passed++;
      do_read();
    end
    checks++; if (buffer_data_present !== 1'b0) $display("FAIL ovr_drained: got %b want 0", buffer_data_present); else passed++;

    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
    ov0 = ov_cycles;
    fork
      send_frame(8'h05, 1'b1);
      begin
        int n;
        n = 0;
        @(negedge clk); #1;
        while (dut.fifo_write !== 1'b1 && n < 1000) begin
          @(negedge clk); #1;
          n++;
        end
        checks++; if (n >= 1000) $display("FAIL write_strobe_timeout: got %0d cycles want <1000", n); else passed++;
        read_buffer = 1'b1;
        @(negedge clk);
        read_buffer = 1'b0;
      end
    join
    checks++; if (ov_cycles - ov0 !== 0) $display("FAIL rw_no_overrun: got %0d want 0", ov_cycles - ov0); else passed++;
    checks++; if (buffer_full !== 1'b1) $display("FAIL rw_still_full: got %b want 1", buffer_full); else passed++;
    for (int k = 2; k <= 5; k++) begin
      checks++; if (data_out !== 8'(k)) $display("FAIL rw_read%0d: got %h want %h", k, data_out, 8'(k)); else passed++;
      do_read();
    end
    checks++; if (buffer_data_present !== 1'b0) $display("FAIL rw_drained: got %b want 0", buffer_data_present); else passed++;
  endtask

  task automatic test_pair();
`ifdef DIFF_UART_RX_PAIR_CHECK_EN
    I = 1'b1; IB = 1'b1;
    wait_clks(6);
    checks++; if (pair_fault !== 1'b0) $display("FAIL pair_early: got %b want 0", pair_fault); else passed++;
    wait_clks(14);
    checks++; if (pair_fault !== 1'b1) $display("FAIL pair_set: got %b want 1", pair_fault); else passed++;
    I = 1'b0; IB = 1'b0;
    wait_clks(700);
    checks++; if (pair_fault !== 1'b1 || buffer_data_present !== 1'b0) $display("FAIL pair_hold: got %b/%b want 1/0", pair_fault, buffer_data_present); else passed++;
    set_line(1'b1);
    wait_clks(4);
    checks++; if (pair_fault !== 1'b0) $display("FAIL pair_clear: got %b want 0", pair_fault); else passed++;
    wait_clks(700);
    checks++; if (buffer_data_present !== 1'b0 || fe_cycles < 0) $display("FAIL pair_no_frame: got %b want 0", buffer_data_present); else passed++;
`else
    I = 1'b1; IB = 1'b1;
    wait_clks(20);
    checks++; if (pair_fault !== 1'b0) $display("FAIL pair_disabled: got %b want 0", pair_fault); else passed++;
    set_line(1'b1);
    wait_clks(4);
`endif
  endtask

  task automatic test_reset_mid();
    int fe0;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    checks++; if ({buffer_data_present, buffer_half_full, data_out} !== {2'b11, 8'h12}) $display("FAIL two_buffered: got %b%b/%h want 11/12", buffer_data_present, buffer_half_full, data_out); else passed++;
    set_line(1'b0);
    wait_clks(64);
    set_line(1'b1);
    wait_clks(100);
    reset_n = 1'b0;
    wait_clks(3);
    checks++; if (data_out !== 8'h00) $display("FAIL midrst_data: got %h want 00", data_out); else passed++;
    checks++; if ({buffer_data_present, buffer_half_full, buffer_full, framing_error, overrun, pair_fault} !== 6'b0) $display("FAIL midrst_flags: got %b want 000000", {buffer_data_present, buffer_half_full, buffer_full, framing_error, overrun, pair_fault}); else passed++;
    reset_n = 1'b1;
    wait_clks(200);
    fe0 = fe_cycles;
    send_frame(8'h7E, 1'b1);
    checks++; if (data_out !== 8'h7E) $display("FAIL post_rst_data: got %h want 7e", data_out); else passed++;
    checks++; if ({buffer_data_present, buffer_half_full} !== 2'b10) $display("FAIL post_rst_count: got %b want 10", {buffer_data_present, buffer_half_full}); else passed++;
    checks++; if (fe_cycles - fe0 !== 0) $display("FAIL post_rst_ferr: got %0d want 0", fe_cycles - fe0); else passed++;
    do_read();
  endtask

  initial begin
    test_reset();
    test_byte();
    test_glitch();
    test_framing();
    test_overrun();
    test_pair();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
